// File: rtl/migration_scheduler.sv
// Cache-line migration scheduler (L2->L1, L3->L2): queues requests from hit
// monitoring and shares one cache access port with demand traffic, which always wins.
module migration_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_SIZE  = 32,
    parameter int QDEPTH     = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_src,
    input  logic                  cpu_busy,
    output logic [1:0]            mem_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [LINE_SIZE-1:0]  mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_wtag,
    input  logic [LINE_SIZE-1:0]  mem_rdata,
    input  logic                  mem_hit,
    output logic                  vic_req,
    output logic [1:0]            vic_level,
    input  logic                  vic_ack,
    input  logic [ADDR_WIDTH-1:0] vic_idx,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] done_addr,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] Q_FULL  = CW'(QDEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT_RD, S_VICTIM, S_WRITE, S_DONE
    } state_t;

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_q_addr [QDEPTH];
    logic [1:0]            r_q_src  [QDEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [LINE_SIZE-1:0]  r_data;
    logic [ADDR_WIDTH-1:0] r_vidx;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;

    logic [PW-1:0]         w_off [QDEPTH];
    logic                  w_dup, w_bad_src, w_accept, w_push, w_drop_req, w_miss, w_pop;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [1:0]            w_head_src, w_dst_lvl;
    logic [1:0]            w_drop_inc;
    logic [CNT_WIDTH:0]    w_drop_sum;

    assign w_head_addr = r_q_addr[r_rd_ptr];
    assign w_head_src  = r_q_src[r_rd_ptr];
    assign w_dst_lvl   = w_head_src - 2'd1;

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign req_ready  = !rst && (r_count < Q_FULL);
    assign busy       = (r_state != S_IDLE) || (r_count != '0);
    assign drop_cnt   = r_drop_cnt;

    assign w_bad_src  = (req_src == 2'd0) || (req_src == 2'd3);
    assign w_accept   = req_valid && req_ready;
    assign w_push     = w_accept && !w_bad_src && !w_dup;
    assign w_drop_req = w_accept && (w_bad_src || w_dup);
    assign w_miss     = (r_state == S_WAIT_RD) && !mem_hit;
    assign w_pop      = w_miss || (r_state == S_DONE);

    // The in-flight migration stays at the head until popped, so scanning the
    // live queue entries also covers the in-flight duplicate case.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            w_off[i] = PW'(i) - r_rd_ptr;
            if (({1'b0, w_off[i]} < r_count) && (r_q_addr[i] == req_addr) &&
                (r_q_src[i] == req_src))
                w_dup = 1'b1;
        end
    end

    // NOTE: queue storage has no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= req_addr;
            r_q_src[r_wr_ptr]  <= req_src;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_drop_inc = {1'b0, w_drop_req} + {1'b0, w_miss};
    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_WIDTH+1)'(w_drop_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_data     <= '0;
            r_vidx     <= '0;
            r_state    <= S_IDLE;
        end else begin
            r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
            if ((r_state == S_WAIT_RD) && mem_hit) r_data <= mem_rdata;
            if ((r_state == S_VICTIM) && vic_ack)  r_vidx <= vic_idx;
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        mem_sel      = '0;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        mem_wtag     = '0;
        vic_req      = 1'b0;
        vic_level    = '0;
        done         = 1'b0;
        done_addr    = '0;
        case (r_state)
            S_IDLE: if (r_count != '0) w_next_state = S_READ;
            S_READ: begin
                if (!cpu_busy) begin
                    mem_rd       = 1'b1;
                    mem_sel      = w_head_src;
                    mem_addr     = w_head_addr;
                    w_next_state = S_WAIT_RD;
                end
            end
            S_WAIT_RD: w_next_state = mem_hit ? S_VICTIM : S_IDLE;
            S_VICTIM: begin
                vic_req   = 1'b1;
                vic_level = w_dst_lvl;
                if (vic_ack) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                if (!cpu_busy) begin
                    mem_wr       = 1'b1;
                    mem_sel      = w_dst_lvl;
                    mem_addr     = r_vidx;
                    mem_wdata    = r_data;
                    mem_wtag     = w_head_addr;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                done_addr    = w_head_addr;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_migration_scheduler.sv
// Directed bench for migration_scheduler: a negedge monitor pops expected read,
// write and completion transactions pushed by the stimulus, plus bus invariants.
module tb_migration_scheduler;
    localparam int AW = 8;
    localparam int LW = 32;
    localparam int QD = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_src;
    logic          cpu_busy;
    logic [1:0]    mem_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_rd, mem_wr;
    logic [LW-1:0] mem_wdata;
    logic [AW-1:0] mem_wtag;
    logic [LW-1:0] mem_rdata;
    logic          mem_hit;
    logic          vic_req;
    logic [1:0]    vic_level;
    logic          vic_ack;
    logic [AW-1:0] vic_idx;
    logic          busy, done;
    logic [AW-1:0] done_addr;
    logic [CW-1:0] drop_cnt;
    logic          ack_en;

    always #5 clk = ~clk;
    assign vic_ack = vic_req & ack_en;

    migration_scheduler #(.ADDR_WIDTH(AW), .LINE_SIZE(LW), .QDEPTH(QD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_src(req_src),
        .cpu_busy(cpu_busy),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_wtag(mem_wtag), .mem_rdata(mem_rdata), .mem_hit(mem_hit),
        .vic_req(vic_req), .vic_level(vic_level), .vic_ack(vic_ack), .vic_idx(vic_idx),
        .busy(busy), .done(done), .done_addr(done_addr), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [AW-1:0] tag;
    } xact_t;

    xact_t         exp_rd[$];
    xact_t         exp_wr[$];
    logic [AW-1:0] exp_done[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_vic    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin : mon
            xact_t e;
            check("strobe_excl", {63'b0, mem_rd & mem_wr}, 64'd0);
            check("strobe_vs_cpu", {63'b0, cpu_busy & (mem_rd | mem_wr)}, 64'd0);
            if (!mem_rd && !mem_wr)
                check("idle_bus_zero", {63'b0, |{mem_sel, mem_addr, mem_wdata, mem_wtag}}, 64'd0);
            if (mem_rd) begin
                check("rd_expected", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    check("rd_sel_addr", {mem_sel, mem_addr}, {e.sel, e.addr});
                end
            end
            if (mem_wr) begin
                check("wr_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr_sel_addr", {mem_sel, mem_addr}, {e.sel, e.addr});
                    check("wr_data", mem_wdata, e.data);
                    check("wr_tag", mem_wtag, e.tag);
                end
            end
            if (vic_req) begin
                n_vic++;
                if (exp_wr.size() != 0) check("vic_level", vic_level, exp_wr[0].sel);
            end
            if (done) begin
                n_done++;
                check("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) check("done_addr", done_addr, exp_done.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_mig(input logic [AW-1:0] a, input logic [1:0] s);
        xact_t r;
        r = '{sel: s, addr: a, data: '0, tag: '0};
        exp_rd.push_back(r);
        r = '{sel: s - 2'd1, addr: vic_idx, data: mem_rdata, tag: a};
        exp_wr.push_back(r);
        exp_done.push_back(a);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [1:0] s);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_src   = s;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        req_valid = 1'b0;
        check("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("drain_timeout", ok, 1);
    endtask

    initial begin : stim
        int            d0, v0;
        logic [CW-1:0] dexp;
        bit            ok;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_src = '0; cpu_busy = 1'b0;
        mem_rdata = '0; mem_hit = 1'b1; vic_idx = '0; ack_en = 1'b1;
        #1;
        check("reset_outs", {63'b0, |{req_ready, mem_sel, mem_addr, mem_rd, mem_wr, mem_wdata,
              mem_wtag, vic_req, vic_level, busy, done, done_addr, drop_cnt}}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();
        check("post_reset", {req_ready, busy, drop_cnt}, {1'b1, 1'b0, 8'h00});

        // Unstalled single migration with exact cycle timing.
        mem_rdata = 32'hDEADBEEF; vic_idx = 8'h05; mem_hit = 1'b1;
        expect_mig(8'h12, 2'd1);
        send(8'h12, 2'd1);
        @(negedge clk); check("t1_e0_idle", {mem_rd, busy}, {1'b0, 1'b1});
        @(negedge clk); check("t1_e1_rd", {mem_rd, mem_sel, mem_addr}, {1'b1, 2'd1, 8'h12});
        @(negedge clk); check("t1_e2_wait", {mem_rd, mem_wr, vic_req}, 3'b000);
        @(negedge clk); check("t1_e3_vic", {vic_req, vic_level}, {1'b1, 2'd0});
        @(negedge clk); check("t1_e4_wr", {mem_wr, mem_sel, mem_addr, mem_wtag}, {1'b1, 2'd0, 8'h05, 8'h12});
        check("t1_e4_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk); check("t1_e5_done", {done, done_addr}, {1'b1, 8'h12});
        @(negedge clk); check("t1_e6_idle", {done, busy}, 2'b00);
        step();

        // Miss path: read only, counted as a drop.
        mem_hit = 1'b0;
        exp_rd.push_back('{sel: 2'd2, addr: 8'h40, data: '0, tag: '0});
        v0 = n_vic;
        send(8'h40, 2'd2);
        wait_idle(50);
        check("t2_drop", drop_cnt, 8'd1);
        check("t2_no_vic", n_vic - v0, 0);
        check("t2_busy", busy, 1'b0);
        mem_hit = 1'b1;
        step();

        // Contention: 3 stalled READ cycles and 2 stalled WRITE cycles.
        mem_rdata = 32'h12345678; vic_idx = 8'h0A;
        expect_mig(8'h21, 2'd1);
        send(8'h21, 2'd1);
        cpu_busy = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            cpu_busy = (k <= 3) || (k >= 6 && k <= 8);
            @(negedge clk);
            if (k == 3)  check("t3_rd_held", mem_rd, 1'b0);
            if (k == 4)  check("t3_rd_late", mem_rd, 1'b1);
            if (k == 8)  check("t3_wr_held", mem_wr, 1'b0);
            if (k == 9)  check("t3_wr_late", {mem_wr, done}, 2'b10);
            if (k == 10) check("t3_done_late", {done, done_addr}, {1'b1, 8'h21});
            if (k == 11) check("t3_idle", busy, 1'b0);
        end
        step();

        // Full queue while the FSM is stalled; 5th accepted only after a pop.
        mem_rdata = 32'hCAFEF00D; vic_idx = 8'h1C;
        cpu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_mig(8'h50 + 8'(i), 2'd1);
            send(8'h50 + 8'(i), 2'd1);
        end
        check("t4_ready_low", req_ready, 1'b0);
        repeat (3) step();
        check("t4_ready_still_low", {req_ready, busy}, 2'b01);
        d0 = n_done;
        cpu_busy = 1'b0;
        expect_mig(8'h54, 2'd1);
        send(8'h54, 2'd1);
        check("t4_5th_after_pop", n_done - d0, 1);
        wait_idle(200);
        check("t4_all_done", n_done - d0, 5);
        check("t4_fifo_drained", exp_done.size(), 0);

        // Filtering: duplicate of a queued entry and an illegal source.
        cpu_busy = 1'b1;
        dexp = drop_cnt + 8'd2;
        d0 = n_done;
        expect_mig(8'h33, 2'd1);
        send(8'h33, 2'd1);
        send(8'h33, 2'd1);
        send(8'h77, 2'd3);
        check("t5_drop", drop_cnt, dexp);
        cpu_busy = 1'b0;
        wait_idle(100);
        check("t5_one_done", n_done - d0, 1);

        // Async reset while waiting in VICTIM.
        ack_en = 1'b0;
        exp_rd.push_back('{sel: 2'd2, addr: 8'h60, data: '0, tag: '0});
        send(8'h60, 2'd2);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (vic_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("t6_reach_victim", ok, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_outs", {63'b0, |{req_ready, mem_sel, mem_addr, mem_rd, mem_wr, mem_wdata,
              mem_wtag, vic_req, vic_level, busy, done, done_addr, drop_cnt}}, 64'd0);
        @(negedge clk) rst = 1'b0;
        ack_en = 1'b1;
        step();
        check("t6_after_rst", {busy, req_ready}, 2'b01);
        d0 = n_done;
        mem_rdata = 32'h0BADF00D; vic_idx = 8'h2E;
        expect_mig(8'h61, 2'd1);
        send(8'h61, 2'd1);
        wait_idle(50);
        check("t6_recover_done", n_done - d0, 1);

        repeat (2) step();
        check("sb_empty", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
